// File: rtl/rand_req_scheduler_pkg.sv
// Shared types and constants for the random request scheduler and its 90-bit generator.
// The generator recurrence lives here so the core and any future users agree on it.
package rand_req_scheduler_pkg;

  localparam int LFSR_W = 90;
  localparam logic [LFSR_W-1:0] LFSR_ONES = {LFSR_W{1'b1}};

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_READY  = 1'b1
  } sched_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Top two bits seed the chain; every lower bit folds in the freshly computed bit two above it.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] n;
    n = '0;
    n[LFSR_W-1] = s[LFSR_W-1] ^ s[1];
    n[LFSR_W-2] = s[LFSR_W-2] ^ s[0];
    for (int i = LFSR_W-3; i >= 0; i--) begin
      n[i] = s[i] ^ n[i+2];
    end
    return n;
  endfunction

endpackage

// File: rtl/rand_req_scheduler_if.sv
// Requester-side bus of the random request scheduler: request pulses, reseed, and tagged grant.
interface rand_req_scheduler_if
  import rand_req_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int OUT_W = 8,
  parameter int ID_W  = id_width(N_REQ)
);

  logic [N_REQ-1:0]  req;
  logic              seed_wr;
  logic [LFSR_W-1:0] seed;
  logic              ready;
  logic [N_REQ-1:0]  gnt;
  logic              rnd_valid;
  logic [OUT_W-1:0]  rnd_data;
  logic [ID_W-1:0]   rnd_id;

  modport master (
    output req, seed_wr, seed,
    input  ready, gnt, rnd_valid, rnd_data, rnd_id
  );

  modport slave (
    input  req, seed_wr, seed,
    output ready, gnt, rnd_valid, rnd_data, rnd_id
  );

endinterface

// File: rtl/rand_lfsr90_core.sv
// 90-bit pseudo-random generator state with step/load control; a zero seed is replaced by all ones
// because the all-zero state never leaves itself.
module rand_lfsr90_core
  import rand_req_scheduler_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_step,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_seed,
  output logic [OUT_W-1:0]  o_rnd
);

  logic [LFSR_W-1:0] r_state;
  logic [LFSR_W-1:0] w_next;
  logic [LFSR_W-1:0] w_seed_safe;

  assign w_next      = lfsr_next(r_state);
  assign w_seed_safe = (i_seed == '0) ? LFSR_ONES : i_seed;
  assign o_rnd       = r_state[OUT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LFSR_ONES;
    end else if (i_load) begin
      r_state <= w_seed_safe;
    end else if (i_step) begin
      r_state <= w_next;
    end
  end

endmodule

// File: rtl/rand_req_scheduler.sv
// Shares the 90-bit generator among N_REQ requesters: warm-up, round-robin grant, tagged random slice.
// Build option RAND_IDLE_STEP_EN: when defined, the generator also steps on idle READY cycles.
module rand_req_scheduler
  import rand_req_scheduler_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int OUT_W         = 8,
  parameter int WARMUP_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rand_req_scheduler_if.slave  bus
);

  localparam int ID_W = id_width(N_REQ);
  localparam logic [7:0]      WARM_LAST = 8'(WARMUP_CYCLES - 1);
  localparam logic [ID_W-1:0] PTR_LAST  = ID_W'(N_REQ - 1);

  sched_state_e      r_state;
  logic [7:0]        r_warm_cnt;
  logic [N_REQ-1:0]  r_pend;
  logic [ID_W-1:0]   r_ptr;
  logic [N_REQ-1:0]  r_gnt;
  logic              r_rnd_valid;
  logic [OUT_W-1:0]  r_rnd_data;
  logic [ID_W-1:0]   r_rnd_id;
  logic              r_ready;

  logic [OUT_W-1:0]  w_rnd;
  logic              w_step;
  logic              w_grant;
  logic              w_found;
  logic [ID_W-1:0]   w_idx;
  logic [ID_W-1:0]   w_winner;
  logic [ID_W-1:0]   w_next_ptr;
  logic [N_REQ-1:0]  w_winner_oh;
  logic [N_REQ-1:0]  w_pend_clr;

  // First pending bit at or above the pointer, wrapping modulo N_REQ.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = ID_W'((int'(r_ptr) + k) % N_REQ);
      if (!w_found && r_pend[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_winner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << w_winner;
  assign w_next_ptr  = (w_winner == PTR_LAST) ? '0 : w_winner + 1'b1;
  assign w_grant     = (r_state == ST_READY) && !bus.seed_wr && w_found;
  assign w_pend_clr  = w_grant ? w_winner_oh : '0;

`ifdef RAND_IDLE_STEP_EN
  assign w_step = !bus.seed_wr;
`else
  assign w_step = !bus.seed_wr && ((r_state == ST_WARMUP) || w_grant);
`endif

  rand_lfsr90_core #(
    .OUT_W (OUT_W)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_step (w_step),
    .i_load (bus.seed_wr),
    .i_seed (bus.seed),
    .o_rnd  (w_rnd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_WARMUP;
      r_warm_cnt  <= '0;
      r_pend      <= '0;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_rnd_valid <= 1'b0;
      r_rnd_data  <= '0;
      r_rnd_id    <= '0;
      r_ready     <= 1'b0;
    end else begin
      // A request arriving with its own grant keeps the bit set.
      r_pend      <= (r_pend & ~w_pend_clr) | bus.req;
      r_gnt       <= '0;
      r_rnd_valid <= 1'b0;
      if (bus.seed_wr) begin
        r_state    <= ST_WARMUP;
        r_warm_cnt <= '0;
        r_ready    <= 1'b0;
      end else begin
        case (r_state)
          ST_WARMUP: begin
            r_warm_cnt <= r_warm_cnt + 8'd1;
            if (r_warm_cnt == WARM_LAST) begin
              r_state <= ST_READY;
              r_ready <= 1'b1;
            end
          end
          ST_READY: begin
            if (w_grant) begin
              r_gnt       <= w_winner_oh;
              r_rnd_valid <= 1'b1;
              r_rnd_id    <= w_winner;
              r_rnd_data  <= w_rnd;
              r_ptr       <= w_next_ptr;
            end
          end
          default: r_state <= ST_WARMUP;
        endcase
      end
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.rnd_valid = r_rnd_valid;
  assign bus.rnd_data  = r_rnd_data;
  assign bus.rnd_id    = r_rnd_id;
  assign bus.ready     = r_ready;

endmodule

// File: tb/tb_rand_req_scheduler.sv
// Self-checking bench for rand_req_scheduler: directed scenarios plus randomized traffic
// compared against a behavioural model of the grant stream and generator.
module tb_rand_req_scheduler;

  localparam int N   = 4;
  localparam int OW  = 8;
  localparam int WU  = 16;
  localparam int IDW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  rand_req_scheduler_if #(.N_REQ(N), .OUT_W(OW)) bus ();

  rand_req_scheduler #(.N_REQ(N), .OUT_W(OW), .WARMUP_CYCLES(WU)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int g_steps = 0;

  // Each new bit is its own bit XOR every same-parity bit above it XOR the low bit of that parity.
  function automatic logic [89:0] ref_step(input logic [89:0] s);
    logic [89:0] n;
    logic b;
    n = '0;
    for (int i = 0; i < 90; i++) begin
      b = s[i % 2];
      for (int j = i; j < 90; j += 2) b = b ^ s[j];
      n[i] = b;
    end
    return n;
  endfunction

  function automatic logic [OW-1:0] val_after(input int k);
    logic [89:0] s;
    s = '1;
    for (int i = 0; i < k; i++) s = ref_step(s);
    return s[OW-1:0];
  endfunction

  // Behavioural model of the whole block, advanced on the same edges as the DUT.
  logic [89:0]   m_s;
  bit            m_ready;
  int            m_warm;
  bit [N-1:0]    m_pend;
  int            m_ptr;
  int            m_w;
  logic [N-1:0]  e_gnt;
  logic          e_valid;
  logic [OW-1:0] e_data;
  logic [IDW-1:0] e_id;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s = '1; m_ready = 0; m_warm = 0; m_pend = '0; m_ptr = 0;
      e_gnt = '0; e_valid = 1'b0; e_data = '0; e_id = '0;
    end else begin
      e_gnt = '0; e_valid = 1'b0; m_w = -1;
      if (bus.seed_wr) begin
        m_s = (bus.seed == '0) ? '1 : bus.seed;
        m_ready = 0; m_warm = 0;
      end else if (!m_ready) begin
        m_s = ref_step(m_s);
        m_warm++;
        if (m_warm == WU) m_ready = 1;
      end else begin
        for (int k = 0; k < N; k++)
          if (m_w < 0 && m_pend[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
        if (m_w >= 0) begin
          e_gnt = N'(1) << m_w; e_valid = 1'b1; e_id = IDW'(m_w);
          e_data = m_s[OW-1:0];
          m_s = ref_step(m_s);
          m_pend[m_w] = 1'b0;
          m_ptr = (m_w + 1) % N;
        end
      end
      m_pend = m_pend | bus.req;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; bus.req = '0; bus.seed_wr = 1'b0; bus.seed = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; bus.req = '0; bus.seed_wr = 1'b0;
    #1;
    checks++;
    if ({bus.ready, bus.gnt, bus.rnd_valid, bus.rnd_data, bus.rnd_id} !== '0)
      begin errors++; $display("FAIL reset_outputs: got rdy=%b gnt=%b v=%b d=%h id=%0d required all 0",
        bus.ready, bus.gnt, bus.rnd_valid, bus.rnd_data, bus.rnd_id); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= WU + 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.ready !== 1'(k >= WU))
        begin errors++; $display("FAIL warmup_ready edge %0d: got %b required %b", k, bus.ready, k >= WU); end
      checks++;
      if (bus.gnt !== '0)
        begin errors++; $display("FAIL warmup_no_gnt edge %0d: got %b required 0", k, bus.gnt); end
    end
  endtask

  task automatic test_warmup_burst();
    logic [OW-1:0] exp_d;
    logic [N-1:0]  exp_g;
    do_reset();
    @(negedge clk);
    bus.req = '1;
    @(negedge clk);
    bus.req = '0;
    for (int k = 3; k <= WU; k++) @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1 || bus.gnt !== '0)
      begin errors++; $display("FAIL burst_ready: got rdy=%b gnt=%b required 1/0", bus.ready, bus.gnt); end
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      exp_d = val_after(WU + i);
      exp_g = N'(1) << i;
      checks++;
      if (bus.gnt !== exp_g || bus.rnd_valid !== 1'b1 || bus.rnd_id !== IDW'(i) || bus.rnd_data !== exp_d)
        begin errors++; $display("FAIL burst_grant %0d: got gnt=%b v=%b id=%0d d=%h required gnt=%b v=1 id=%0d d=%h",
          i, bus.gnt, bus.rnd_valid, bus.rnd_id, bus.rnd_data, exp_g, i, exp_d); end
    end
    @(negedge clk);
    exp_d = val_after(WU + N - 1);
    checks++;
    if (bus.gnt !== '0 || bus.rnd_valid !== 1'b0 || bus.rnd_data !== exp_d)
      begin errors++; $display("FAIL burst_idle: got gnt=%b v=%b d=%h required 0/0/%h",
        bus.gnt, bus.rnd_valid, bus.rnd_data, exp_d); end
    g_steps = WU + N;
  endtask

  task automatic test_wrap();
    logic [OW-1:0] exp_d;
    bus.req = 4'b0100;
    @(negedge clk); bus.req = '0;
    @(negedge clk);
    exp_d = val_after(g_steps);
    checks++;
    if (bus.gnt !== 4'b0100 || bus.rnd_id !== 2'd2 || bus.rnd_data !== exp_d)
      begin errors++; $display("FAIL wrap_first: got gnt=%b id=%0d d=%h required 0100 id=2 d=%h",
        bus.gnt, bus.rnd_id, bus.rnd_data, exp_d); end
    bus.req = 4'b0101;
    @(negedge clk); bus.req = '0;
    @(negedge clk);
    exp_d = val_after(g_steps + 1);
    checks++;
    if (bus.gnt !== 4'b0001 || bus.rnd_id !== 2'd0 || bus.rnd_data !== exp_d)
      begin errors++; $display("FAIL wrap_zero: got gnt=%b id=%0d d=%h required 0001 id=0 d=%h",
        bus.gnt, bus.rnd_id, bus.rnd_data, exp_d); end
    @(negedge clk);
    exp_d = val_after(g_steps + 2);
    checks++;
    if (bus.gnt !== 4'b0100 || bus.rnd_id !== 2'd2 || bus.rnd_data !== exp_d)
      begin errors++; $display("FAIL wrap_two: got gnt=%b id=%0d d=%h required 0100 id=2 d=%h",
        bus.gnt, bus.rnd_id, bus.rnd_data, exp_d); end
    @(negedge clk);
    checks++;
    if (bus.gnt !== '0 || bus.rnd_valid !== 1'b0 || bus.rnd_data !== exp_d)
      begin errors++; $display("FAIL wrap_hold: got gnt=%b v=%b d=%h required 0/0/%h",
        bus.gnt, bus.rnd_valid, bus.rnd_data, exp_d); end
    g_steps += 3;
  endtask

  task automatic test_merge();
    logic [OW-1:0] exp_d;
    bus.req = 4'b0010;
    @(negedge clk);
    @(negedge clk); bus.req = '0;
    exp_d = val_after(g_steps);
    checks++;
    if (bus.gnt !== 4'b0010 || bus.rnd_data !== exp_d)
      begin errors++; $display("FAIL merge_first: got gnt=%b d=%h required 0010 d=%h", bus.gnt, bus.rnd_data, exp_d); end
    @(negedge clk);
    exp_d = val_after(g_steps + 1);
    checks++;
    if (bus.gnt !== 4'b0010 || bus.rnd_data !== exp_d)
      begin errors++; $display("FAIL set_wins_regrant: got gnt=%b d=%h required 0010 d=%h", bus.gnt, bus.rnd_data, exp_d); end
    @(negedge clk);
    checks++;
    if (bus.gnt !== '0)
      begin errors++; $display("FAIL merge_no_third: got gnt=%b required 0", bus.gnt); end
    g_steps += 2;
  endtask

  task automatic test_reseed();
    logic [OW-1:0] exp_d;
    int e;
    bus.req = 4'b0001;
    @(negedge clk);
    bus.req = '0; bus.seed_wr = 1'b1; bus.seed = '0;
    @(negedge clk);
    bus.seed_wr = 1'b0;
    checks++;
    if (bus.gnt !== '0 || bus.ready !== 1'b0)
      begin errors++; $display("FAIL reseed_cycle: got gnt=%b rdy=%b required 0/0", bus.gnt, bus.ready); end
    e = 0;
    bus.req = 4'b0010;
    @(negedge clk); e++; bus.req = '0;
    @(negedge clk); e++; bus.req = 4'b0010;
    @(negedge clk); e++; bus.req = '0;
    while (e < WU - 1) begin @(negedge clk); e++; end
    checks++;
    if (bus.ready !== 1'b0 || bus.gnt !== '0)
      begin errors++; $display("FAIL reseed_warm_%0d: got rdy=%b gnt=%b required 0/0", e, bus.ready, bus.gnt); end
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1)
      begin errors++; $display("FAIL reseed_ready: got %b required 1", bus.ready); end
    @(negedge clk);
    exp_d = val_after(WU);
    checks++;
    if (bus.gnt !== 4'b0001 || bus.rnd_data !== exp_d)
      begin errors++; $display("FAIL reseed_first: got gnt=%b d=%h required 0001 d=%h", bus.gnt, bus.rnd_data, exp_d); end
    @(negedge clk);
    exp_d = val_after(WU + 1);
    checks++;
    if (bus.gnt !== 4'b0010 || bus.rnd_data !== exp_d)
      begin errors++; $display("FAIL reseed_merged: got gnt=%b d=%h required 0010 d=%h", bus.gnt, bus.rnd_data, exp_d); end
    @(negedge clk);
    checks++;
    if (bus.gnt !== '0)
      begin errors++; $display("FAIL reseed_single: got gnt=%b required 0", bus.gnt); end
  endtask

  task automatic test_reset_mid();
    int t;
    bus.req = 4'b1111;
    @(negedge clk); bus.req = '0;
    t = 0;
    while (bus.gnt === '0 && t < 6) begin @(negedge clk); t++; end
    checks++;
    if (bus.gnt === '0)
      begin errors++; $display("FAIL midreset_wait: got no grant within %0d cycles required a grant", t); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.gnt !== '0 || bus.rnd_valid !== 1'b0 || bus.ready !== 1'b0)
      begin errors++; $display("FAIL midreset_clear: got gnt=%b v=%b rdy=%b required 0/0/0",
        bus.gnt, bus.rnd_valid, bus.ready); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= WU + 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt !== '0 || bus.ready !== 1'(k >= WU))
        begin errors++; $display("FAIL midreset_after edge %0d: got gnt=%b rdy=%b required 0/%b",
          k, bus.gnt, bus.ready, k >= WU); end
    end
  endtask

  task automatic test_random();
    logic [95:0] r;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt !== e_gnt || bus.rnd_valid !== e_valid || bus.rnd_id !== e_id ||
          bus.rnd_data !== e_data || bus.ready !== m_ready)
        begin errors++; $display("FAIL random c%0d: got gnt=%b v=%b id=%0d d=%h rdy=%b required gnt=%b v=%b id=%0d d=%h rdy=%b",
          c, bus.gnt, bus.rnd_valid, bus.rnd_id, bus.rnd_data, bus.ready,
          e_gnt, e_valid, e_id, e_data, m_ready); end
      rst_n = 1'b1;
      bus.req = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      bus.seed_wr = ($urandom_range(0, 60) == 0);
      r = {$urandom, $urandom, $urandom};
      bus.seed = ($urandom_range(0, 3) == 0) ? '0 : r[89:0];
      if ($urandom_range(0, 250) == 0) rst_n = 1'b0;
    end
    @(negedge clk);
    bus.req = '0; bus.seed_wr = 1'b0; rst_n = 1'b1;
  endtask

  initial begin
    bus.req = '0; bus.seed_wr = 1'b0; bus.seed = '0;
    test_reset();
    test_warmup_burst();
    test_wrap();
    test_merge();
    test_reseed();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
